spi_transfer_scheduler: RTL and testbench
=========================================

# spi_transfer_scheduler

Single-clock scheduler that shares the SPI transfer engine between two requesters: requester 0 is the bus-side register interface and requester 1 is the boot/flash loader. It arbitrates access, presents length, mode and chip-select to the engine, issues the start pulse, and waits for completion. It can keep chip-select asserted across back-to-back transfers of one command sequence, and it aborts transfers that hang. It sits between the requesters and the SPI engine, in the engine's clock domain.

## Interface
- LEN_W, 9: transfer length width; the engine transfers length+1 bytes.
- CS_GAP, 2: minimum chip-select-high cycles between owners; must be ≥1.
- TIMEOUT_W, 16: timeout counter width; timeout = 2^TIMEOUT_W−1 cycles.

Ports:
- FastClk  in  1  engine clock.
- Reset  in  1  asynchronous, active-high reset.
- Req  in  2  per-requester level request; bit i belongs to requester i.
- Lock  in  2  per-requester flag: keep chip-select low and keep ownership after the current transfer.
- ReqLen0, ReqLen1  in  LEN_W  transfer length per requester.
- ReqMode0, ReqMode1  in  2  transfer mode per requester (Write/Read/Exchange/WaitAndRead encoding).
- Grant  out  2  one-hot current owner, or 0.
- Done  out  2  one-cycle completion pulse to the owner.
- Err  out  1  held with the Done pulse when that transfer timed out.
- EngLen  out  LEN_W  length presented to the engine.
- EngMode  out  2  mode presented to the engine.
- EngCs  out  1  chip-select, active low.
- EngStart  out  1  one-cycle start pulse.
- EngAbort  out  1  one-cycle abort pulse.
- EngDone  in  1  one-cycle completion pulse from the engine.

## Operation
- States: IDLE, SETUP, START, WAIT, HOLD, GAP.
- IDLE:
  - If any Req bit is set, choose the owner round-robin: when both request, the requester that is not `last` wins; a single request wins alone.
  - Set Grant and latch `last`, then go to SETUP.
- SETUP:
  - Latch the owner's ReqLen and ReqMode into EngLen and EngMode.
  - Drive EngCs low.
  - Go to START.
- START:
  - Pulse EngStart.
  - Clear the timeout counter.
  - Go to WAIT.
- WAIT:
  - On EngDone: pulse Done[owner] with Err=0, then evaluate the lock rule below.
  - On timeout counter all-ones: pulse EngAbort, pulse Done[owner] with Err=1, drive EngCs high, go to GAP. Lock is ignored in this case.
- Lock rule at completion:
  - Lock[owner] low: drive EngCs high and go to GAP.
  - Lock[owner] high and Req[owner] high: go to SETUP; EngCs stays low and ownership is kept.
  - Lock[owner] high and Req[owner] low: go to HOLD.
- HOLD:
  - EngCs stays low and Grant is held.
  - Req[owner] high goes to SETUP. Lock[owner] low (checked with priority over Req) drives EngCs high and goes to GAP.
- GAP:
  - Clear Grant and count CS_GAP cycles with EngCs high.
  - Then go to IDLE.
- A Req deasserted during WAIT does not cancel the transfer; Done still pulses.
- The non-owner's Req is ignored until the scheduler returns to IDLE. Lock never starves the other requester beyond the owner's own sequence.
- Reset values: state IDLE, Grant=0, Done=0, Err=0, EngStart=0, EngAbort=0, EngCs=1, EngLen=0, EngMode=0, `last`=1 (requester 0 wins the first tie).
- Reset asserted mid-transfer: all outputs return to their reset values immediately. No Done is issued; the engine is expected to be reset alongside.

## Timing
- Latency from Req (seen in IDLE) to Grant: 1 cycle.
- Grant to EngCs low: 1 cycle (SETUP). EngCs low to EngStart: 1 cycle.
- So EngStart occurs 3 cycles after Req is first sampled.
- Done is asserted in the cycle after EngDone.
- Chained locked transfer: EngDone to next EngStart takes 3 cycles, with no EngCs high glitch.
- Release: EngCs is high exactly CS_GAP cycles before the next IDLE evaluation.
- Timeout: the counter increments every WAIT cycle. Abort fires in the cycle the counter reads all-ones. An EngDone in that same cycle wins: normal completion.

## Structure
- The shared SPI package holds:
  - the TransferMode enum, used by the engine and this block;
  - the scheduler state enum;
  - the requester-index constants REQ_BUS=0 and REQ_LOADER=1.
- There is no sub-module. The round-robin pick is a few lines inline; a separate `rr_arbiter2` module is not warranted.

## Test plan
- Req=01, ReqLen0=3, Lock=0, EngDone returned 10 cycles after start. Required:
  - Grant=01 at +1, EngStart at +3, Done[0] one cycle after EngDone;
  - EngCs high for 2 cycles, then Grant=0.
- Req=11 raised simultaneously from reset. Required:
  - requester 0 is served first, requester 1 next;
  - then, with both still requesting, requester 0 again.
- Lock0=1, Req0 held for two transfers. Required:
  - EngCs stays low across both transfers;
  - exactly 3 cycles from EngDone to the second EngStart;
  - the second length equals the new ReqLen0.
- Lock0=1, then Req0 dropped. Required:
  - HOLD is entered and Req1 is ignored while held;
  - after Lock0 falls: EngCs high, a gap of CS_GAP cycles, then Grant=10.
- EngDone never returned, TIMEOUT_W=4. Required:
  - EngAbort and Done[owner] with Err=1 fifteen cycles after EngStart;
  - EngCs high.
- Reset pulsed in WAIT. Required: EngCs=1, Grant=0, no Done pulse, and a clean restart afterwards.

Source files
------------

// File: rtl/spi_transfer_scheduler_pkg.sv
// Shared SPI definitions: engine transfer modes, scheduler states and the
// requester indices used by the transfer scheduler.
package spi_transfer_scheduler_pkg;

  // Engine transfer mode encoding, shared with the SPI engine.
  typedef enum logic [1:0] {
    MODE_WRITE     = 2'd0,
    MODE_READ      = 2'd1,
    MODE_EXCHANGE  = 2'd2,
    MODE_WAIT_READ = 2'd3
  } transfer_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } sched_state_t;

  localparam int REQ_BUS    = 0;
  localparam int REQ_LOADER = 1;

  // One-hot grant vector for a requester index.
  function automatic logic [1:0] req_onehot(input logic idx);
    logic [1:0] oh;
    oh = '0;
    oh[idx ? REQ_LOADER : REQ_BUS] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/spi_transfer_scheduler.sv
// Shares one SPI transfer engine between the bus register interface
// (requester 0) and the boot/flash loader (requester 1).
//
// Ports:
//   FastClk, Reset        engine clock, async active-high reset
//   Req[1:0], Lock[1:0]   per-requester request level / keep-CS-and-ownership
//   ReqLen0/1, ReqMode0/1 per-requester transfer length and mode
//   Grant[1:0]            one-hot current owner (0 when free)
//   Done[1:0], Err        completion pulse to owner, Err marks a timeout
//   EngLen, EngMode       transfer parameters presented to the engine
//   EngCs                 chip-select, active low
//   EngStart, EngAbort    one-cycle engine start / abort pulses
//   EngDone               one-cycle completion pulse from the engine
module spi_transfer_scheduler
  import spi_transfer_scheduler_pkg::*;
#(
  parameter int LEN_W     = 9,
  parameter int CS_GAP    = 2,
  parameter int TIMEOUT_W = 16
) (
  input  logic             FastClk,
  input  logic             Reset,
  input  logic [1:0]       Req,
  input  logic [1:0]       Lock,
  input  logic [LEN_W-1:0] ReqLen0,
  input  logic [LEN_W-1:0] ReqLen1,
  input  logic [1:0]       ReqMode0,
  input  logic [1:0]       ReqMode1,
  output logic [1:0]       Grant,
  output logic [1:0]       Done,
  output logic             Err,
  output logic [LEN_W-1:0] EngLen,
  output logic [1:0]       EngMode,
  output logic             EngCs,
  output logic             EngStart,
  output logic             EngAbort,
  input  logic             EngDone
);

  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
  // Abort is decided on the edge where the count steps to all-ones, so the
  // abort pulse and the all-ones count appear in the same cycle,
  // 2^TIMEOUT_W-1 cycles after EngStart.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  sched_state_t         state, state_nxt;
  logic                 owner, owner_nxt;
  logic                 last, last_nxt;
  logic                 pick;
  logic                 own_req, own_lock;
  logic [1:0]           grant_q, grant_nxt;
  logic [1:0]           done_q, done_nxt;
  logic                 err_q, err_nxt;
  logic                 start_q, start_nxt;
  logic                 abort_q, abort_nxt;
  logic                 cs_q, cs_nxt;
  logic [LEN_W-1:0]     len_q, len_nxt;
  transfer_mode_t       mode_q, mode_nxt;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_nxt;
  logic [GAP_W-1:0]     gap_q, gap_nxt;

  assign own_req  = Req[owner];
  assign own_lock = Lock[owner];

  // Round-robin: on a tie the requester that did not win last time goes;
  // a lone request wins outright (Req[1] set alone selects requester 1).
  assign pick = (Req == 2'b11) ? ~last : Req[REQ_LOADER];

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    grant_nxt = grant_q;
    done_nxt  = '0;
    err_nxt   = 1'b0;
    start_nxt = 1'b0;
    abort_nxt = 1'b0;
    cs_nxt    = cs_q;
    len_nxt   = len_q;
    mode_nxt  = mode_q;
    tmo_nxt   = tmo_q;
    gap_nxt   = gap_q;

    unique case (state)
      ST_IDLE: begin
        if (|Req) begin
          owner_nxt = pick;
          last_nxt  = pick;
          grant_nxt = req_onehot(pick);
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        len_nxt   = owner ? ReqLen1 : ReqLen0;
        mode_nxt  = transfer_mode_t'(owner ? ReqMode1 : ReqMode0);
        cs_nxt    = 1'b0;
        state_nxt = ST_START;
      end
      ST_START: begin
        start_nxt = 1'b1;
        tmo_nxt   = '0;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        tmo_nxt = tmo_q + 1'b1;
        // A completion on the timeout edge still counts as a normal finish.
        if (EngDone) begin
          done_nxt = req_onehot(owner);
          if (!own_lock) begin
            cs_nxt    = 1'b1;
            gap_nxt   = '0;
            state_nxt = ST_GAP;
          end else if (own_req) begin
            state_nxt = ST_SETUP;
          end else begin
            state_nxt = ST_HOLD;
          end
        end else if (tmo_q == TMO_LAST) begin
          abort_nxt = 1'b1;
          done_nxt  = req_onehot(owner);
          err_nxt   = 1'b1;
          cs_nxt    = 1'b1;
          gap_nxt   = '0;
          state_nxt = ST_GAP;
        end
      end
      ST_HOLD: begin
        // Dropping Lock releases the bus even if a new request is pending.
        if (!own_lock) begin
          cs_nxt    = 1'b1;
          gap_nxt   = '0;
          state_nxt = ST_GAP;
        end else if (own_req) begin
          state_nxt = ST_SETUP;
        end
      end
      ST_GAP: begin
        grant_nxt = '0;
        cs_nxt    = 1'b1;
        if (gap_q == GAP_LAST) state_nxt = ST_IDLE;
        else                   gap_nxt   = gap_q + 1'b1;
      end
      default: begin
        grant_nxt = '0;
        cs_nxt    = 1'b1;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge FastClk or posedge Reset) begin
    if (Reset) begin
      state   <= ST_IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      cs_q    <= 1'b1;
      len_q   <= '0;
      mode_q  <= MODE_WRITE;
      tmo_q   <= '0;
      gap_q   <= '0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      last    <= last_nxt;
      grant_q <= grant_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      start_q <= start_nxt;
      abort_q <= abort_nxt;
      cs_q    <= cs_nxt;
      len_q   <= len_nxt;
      mode_q  <= mode_nxt;
      tmo_q   <= tmo_nxt;
      gap_q   <= gap_nxt;
    end
  end

  assign Grant    = grant_q;
  assign Done     = done_q;
  assign Err      = err_q;
  assign EngLen   = len_q;
  assign EngMode  = mode_q;
  assign EngCs    = cs_q;
  assign EngStart = start_q;
  assign EngAbort = abort_q;

endmodule

// File: tb/tb_spi_transfer_scheduler.sv
// Self-checking bench for spi_transfer_scheduler: a per-cycle vector table for
// a plain transfer, hand-written lock/hold/timeout/reset sequences, and a
// randomized run checked against a transaction-level owner/timing model.
module tb_spi_transfer_scheduler;

  localparam int LEN_W     = 9;
  localparam int CS_GAP    = 2;
  localparam int TIMEOUT_W = 4;

  logic             FastClk = 1'b0;
  logic             Reset;
  logic [1:0]       Req, Lock;
  logic [LEN_W-1:0] ReqLen0, ReqLen1;
  logic [1:0]       ReqMode0, ReqMode1;
  logic [1:0]       Grant, Done;
  logic             Err;
  logic [LEN_W-1:0] EngLen;
  logic [1:0]       EngMode;
  logic             EngCs, EngStart, EngAbort, EngDone;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  spi_transfer_scheduler #(.LEN_W(LEN_W), .CS_GAP(CS_GAP), .TIMEOUT_W(TIMEOUT_W)) dut (
    .FastClk(FastClk), .Reset(Reset), .Req(Req), .Lock(Lock),
    .ReqLen0(ReqLen0), .ReqLen1(ReqLen1), .ReqMode0(ReqMode0), .ReqMode1(ReqMode1),
    .Grant(Grant), .Done(Done), .Err(Err), .EngLen(EngLen), .EngMode(EngMode),
    .EngCs(EngCs), .EngStart(EngStart), .EngAbort(EngAbort), .EngDone(EngDone)
  );

  always #5 FastClk = ~FastClk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, want finish");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]       req;
    logic             ed;
    logic [1:0]       grant;
    logic             cs;
    logic             start;
    logic [1:0]       done;
    logic [LEN_W-1:0] len;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic [1:0] req, input logic ed, input logic [1:0] grant,
                              input logic cs, input logic start, input logic [1:0] done,
                              input logic [LEN_W-1:0] len);
    vec_t v;
    v.req = req; v.ed = ed; v.grant = grant; v.cs = cs; v.start = start; v.done = done; v.len = len;
    return v;
  endfunction

  // One clock: inputs set before the call are sampled on the posedge,
  // outputs are read on the following negedge.
  task automatic step();
    @(posedge FastClk);
    cyc++;
    @(negedge FastClk);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; Req = '0; Lock = '0; EngDone = 1'b0;
    ReqLen0 = '0; ReqLen1 = '0; ReqMode0 = '0; ReqMode1 = '0;
    step(); step();
    chk("reset_state", {Grant, Done, Err, EngStart, EngAbort, EngCs, EngLen, EngMode},
        {2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 9'd0, 2'b00});
    Reset = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_start(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (EngStart) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL wait_start: got no EngStart want EngStart within %0d cycles", bound);
    end
  endtask

  task automatic serve(input string nm, input logic [1:0] exp_g);
    bit ok;
    wait_start(40, ok);
    if (ok) begin
      chk({nm, "_grant"}, Grant, exp_g);
      step();
      EngDone = 1'b1; step(); EngDone = 1'b0;
      chk({nm, "_done"}, {Done, Err}, {exp_g, 1'b0});
    end
  endtask

  initial begin
    bit ok;
    int m_last, m_owner, owner, d, exp_start, t_done;
    bit chained, lock_c;
    logic [1:0] og;
    logic [LEN_W-1:0] exp_len;
    logic [1:0] exp_mode;

    // ---- plain transfer, cycle by cycle ----
    tbl[0] = mk(2'b01, 0, 2'b01, 1, 0, 2'b00, 9'd0);
    tbl[1] = mk(2'b01, 0, 2'b01, 0, 0, 2'b00, 9'd3);
    tbl[2] = mk(2'b01, 0, 2'b01, 0, 1, 2'b00, 9'd3);
    for (int i = 3; i <= 12; i++) tbl[i] = mk(2'b01, 0, 2'b01, 0, 0, 2'b00, 9'd3);
    tbl[13] = mk(2'b00, 1, 2'b01, 1, 0, 2'b01, 9'd3);
    tbl[14] = mk(2'b00, 0, 2'b00, 1, 0, 2'b00, 9'd3);
    tbl[15] = mk(2'b00, 0, 2'b00, 1, 0, 2'b00, 9'd3);
    tbl[16] = mk(2'b01, 0, 2'b01, 1, 0, 2'b00, 9'd3);
    tbl[17] = mk(2'b01, 0, 2'b01, 0, 0, 2'b00, 9'd3);
    tbl[18] = mk(2'b01, 0, 2'b01, 0, 1, 2'b00, 9'd3);

    do_reset();
    ReqLen0 = 9'd3; ReqMode0 = 2'd2;
    for (int i = 0; i < 19; i++) begin
      Req = tbl[i].req; EngDone = tbl[i].ed;
      step();
      chk($sformatf("vec%0d", i), {Grant, EngCs, EngStart, Done, Err, EngAbort, EngLen},
          {tbl[i].grant, tbl[i].cs, tbl[i].start, tbl[i].done, 2'b00, tbl[i].len});
    end
    EngDone = 1'b0;

    // ---- tie from reset: 0, 1, 0 ----
    do_reset();
    Req = 2'b11; ReqLen0 = 9'd7; ReqLen1 = 9'd9;
    serve("rr_first", 2'b01);
    serve("rr_second", 2'b10);
    serve("rr_third", 2'b01);

    // ---- locked chain, non-owner requesting throughout ----
    do_reset();
    ReqLen0 = 9'd4; ReqMode0 = 2'd1; Req = 2'b11; Lock = 2'b01;
    wait_start(10, ok);
    chk("lock_first", {Grant, EngCs, EngLen, EngMode}, {2'b01, 1'b0, 9'd4, 2'b01});
    step(); step();
    ReqLen0 = 9'd9; EngDone = 1'b1; step(); EngDone = 1'b0;
    chk("lock_done", {Done, Err, EngCs, Grant}, {2'b01, 1'b0, 1'b0, 2'b01});
    step();
    chk("lock_setup", {EngCs, EngStart, Grant}, {1'b0, 1'b0, 2'b01});
    step();
    chk("lock_restart", {EngCs, EngStart, Grant, EngLen}, {1'b0, 1'b1, 2'b01, 9'd9});
    Lock = 2'b00; step();
    EngDone = 1'b1; step(); EngDone = 1'b0;
    chk("lock_end", {Done, EngCs}, {2'b01, 1'b1});

    // ---- hold, then release to the other requester ----
    do_reset();
    ReqLen0 = 9'd2; Req = 2'b01; Lock = 2'b01;
    wait_start(10, ok);
    step();
    Req = 2'b10; EngDone = 1'b1; step(); EngDone = 1'b0;
    chk("hold_done", {Done, EngCs}, {2'b01, 1'b0});
    for (int k = 0; k < 4; k++) begin
      step();
      chk("hold_keep", {Grant, EngCs, EngStart}, {2'b01, 1'b0, 1'b0});
    end
    Lock = 2'b00; step();
    chk("hold_release", {EngCs, Grant}, {1'b1, 2'b01});
    step(); step();
    chk("hold_gap", {EngCs, Grant}, {1'b1, 2'b00});
    step();
    chk("hold_next", Grant, 2'b10);

    // ---- timeout, then EngDone on the last allowed cycle ----
    do_reset();
    Req = 2'b10; ReqLen1 = 9'd1;
    wait_start(10, ok);
    Req = 2'b00;
    for (int k = 1; k <= 14; k++) step();
    chk("tmo_before", {EngAbort, Done}, 3'b000);
    step();
    chk("tmo_abort", {EngAbort, Done, Err, EngCs}, {1'b1, 2'b10, 1'b1, 1'b1});
    step();
    chk("tmo_pulse", {EngAbort, Done, Err}, 4'b0000);
    Req = 2'b10;
    wait_start(20, ok);
    Req = 2'b00;
    for (int k = 1; k <= 14; k++) step();
    EngDone = 1'b1; step(); EngDone = 1'b0;
    chk("tmo_tie", {EngAbort, Done, Err}, {1'b0, 2'b10, 1'b0});

    // ---- reset in WAIT ----
    do_reset();
    Req = 2'b01;
    wait_start(10, ok);
    step(); step();
    #2 Reset = 1'b1;
    #1 chk("rst_async", {Grant, EngCs, EngStart, Done}, {2'b00, 1'b1, 1'b0, 2'b00});
    EngDone = 1'b1; step(); EngDone = 1'b0;
    chk("rst_nodone", {Done, Err}, 3'b000);
    Reset = 1'b0;
    step();
    chk("rst_regrant", {Grant, EngCs}, {2'b01, 1'b1});
    step(); step();
    chk("rst_restart", {EngStart, EngCs}, {1'b1, 1'b0});

    // ---- randomized against the transaction model ----
    do_reset();
    m_last = 1; m_owner = 0; chained = 0;
    ReqLen0 = LEN_W'($urandom); ReqLen1 = LEN_W'($urandom);
    ReqMode0 = 2'($urandom); ReqMode1 = 2'($urandom);
    Req = 2'($urandom_range(1, 3));
    exp_start = cyc + 3;
    for (int n = 0; n < 60; n++) begin
      if (chained) owner = m_owner;
      else begin
        owner = (Req == 2'b11) ? ((m_last == 1) ? 0 : 1) : (Req[1] ? 1 : 0);
        m_last = owner;
      end
      m_owner  = owner;
      og       = (owner == 1) ? 2'b10 : 2'b01;
      exp_len  = (owner == 1) ? ReqLen1 : ReqLen0;
      exp_mode = (owner == 1) ? ReqMode1 : ReqMode0;
      wait_start(40, ok);
      if (!ok) break;
      chk("rnd_start", {16'(cyc), Grant, EngLen, EngMode, EngCs},
          {16'(exp_start), og, exp_len, exp_mode, 1'b0});
      lock_c = ($urandom_range(0, 3) == 0);
      Lock = 2'($urandom_range(0, 3));
      Lock[owner] = lock_c;
      Req[1-owner] = 1'($urandom_range(0, 1));
      if (lock_c) Req[owner] = 1'b1;
      else if ($urandom_range(0, 1) == 1) Req[owner] = 1'b0;
      d = $urandom_range(1, 12);
      repeat (d - 1) step();
      EngDone = 1'b1; step(); EngDone = 1'b0;
      chk("rnd_done", {Done, Err, EngAbort, EngCs}, {og, 1'b0, 1'b0, ~lock_c});
      t_done  = cyc;
      chained = lock_c;
      exp_start = lock_c ? (t_done + 2) : (t_done + CS_GAP + 3);
      Lock = 2'b00;
      ReqLen0 = LEN_W'($urandom); ReqLen1 = LEN_W'($urandom);
      ReqMode0 = 2'($urandom); ReqMode1 = 2'($urandom);
      if (lock_c) Req[1-owner] = 1'($urandom_range(0, 1));
      else Req = 2'($urandom_range(1, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
